// File: rtl/theta_column_parity_if.sv
// ---------------------------------------------------------------------------
// theta_column_parity_if
// Purpose : slice stream bundle between the file-reader path, the column-parity
//           mixing stage and the downstream swap stage.
// Signals : in_valid/in_ready/in_line    - upstream slice stream (N bits)
//           out_valid/out_ready/out_line - downstream mixed slice stream
// Handshake: a transfer happens on a rising clk edge where valid && ready are
//           both 1. A source may not retract valid or change its data while
//           valid=1 and ready=0. A sink may drive ready independently of valid.
// Modports: slave  - the mixing stage (consumes in_*, produces out_*)
//           master - the environment driving the stage
// ---------------------------------------------------------------------------
interface theta_column_parity_if #(
   parameter int N = 25
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_line;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_line;

   modport slave (
      input  in_valid,
      input  in_line,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_line
   );

   modport master (
      output in_valid,
      output in_line,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_line
   );
endinterface

// File: rtl/theta_column_parity.sv
// ---------------------------------------------------------------------------
// theta_column_parity
// Purpose : buffers one frame of LINES 5x5 slices (bit i at x=i%5, y=i/5),
//           then emits every slice z XORed with the column parity of slice z
//           (column x-1) and of slice z-1 with wrap-around (column x+1).
// Ports   : clk          - rising-edge clock
//           rst          - synchronous active-high reset, highest priority
//           bus          - slave view of theta_column_parity_if (in_*, out_*)
//           busy         - frame in progress
//           done         - one-cycle pulse after the last output handshake
//           o_dbg_state  - current FSM state (0 = LOAD, 1 = EMIT)
//           o_dbg_rd_idx - current emit index
// ---------------------------------------------------------------------------
module theta_column_parity #(
   parameter int N     = 25,
   parameter int LINES = 64,
   parameter int AW    = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   theta_column_parity_if.slave bus,
   output logic                 busy,
   output logic                 done,
   output logic                 o_dbg_state,
   output logic [AW-1:0]        o_dbg_rd_idx
);

   typedef enum logic {
      S_LOAD = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [AW-1:0] r_wr_idx;
   logic [AW-1:0] r_rd_idx;
   logic [AW-1:0] w_wr_idx_nxt;
   logic [AW-1:0] w_rd_idx_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic          w_in_fire;
   logic          w_mem_we;

   // Frame storage; never reset, contents are only read after being written.
   logic [N-1:0]  r_mem [LINES];
   logic [4:0]    r_par [LINES];

   logic [4:0]    w_in_par;
   logic [4:0]    w_cur_par;
   logic [4:0]    w_prev_par;
   logic [N-1:0]  w_cur_slice;
   logic [N-1:0]  w_mix;
   logic [AW-1:0] w_prev_idx;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_LOAD;
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_wr_idx <= w_wr_idx_nxt;
         r_rd_idx <= w_rd_idx_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and index updates. Indices are AW bits wide and LINES is
   // 2**AW, so the increments wrap to 0 at the end of a frame by themselves.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_wr_idx_nxt = r_wr_idx;
      w_rd_idx_nxt = r_rd_idx;
      w_done_nxt   = 1'b0;
      w_in_fire    = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_in_fire = bus.in_valid;
            if (bus.in_valid) begin
               w_wr_idx_nxt = r_wr_idx + AW'(1);
               if (r_wr_idx == AW'(LINES - 1)) begin
                  w_next_state = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               w_rd_idx_nxt = r_rd_idx + AW'(1);
               if (r_rd_idx == AW'(LINES - 1)) begin
                  w_next_state = S_LOAD;
                  w_done_nxt   = 1'b1;
               end
            end
         end
         default: begin
            w_next_state = S_LOAD;
         end
      endcase
   end

   // Reset wins over a coincident accept, so the buffer is not written then.
   assign w_mem_we = w_in_fire & ~rst;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_wr_idx] <= bus.in_line;
         r_par[r_wr_idx] <= w_in_par;
      end
   end

   // Column parity of the incoming slice: XOR of the five bits of column x.
   for (genvar x = 0; x < 5; x++) begin : gen_par
      assign w_in_par[x] = bus.in_line[x]      ^ bus.in_line[x + 5] ^
                           bus.in_line[x + 10] ^ bus.in_line[x + 15] ^
                           bus.in_line[x + 20];
   end

   // Emit path reads only registered state (buffer + rd index), so out_line
   // has no combinational dependency on in_* or out_ready.
   assign w_prev_idx  = r_rd_idx - AW'(1);
   assign w_cur_slice = r_mem[r_rd_idx];
   assign w_cur_par   = r_par[r_rd_idx];
   assign w_prev_par  = r_par[w_prev_idx];

   for (genvar i = 0; i < N; i++) begin : gen_mix
      localparam int X = i % 5;
      assign w_mix[i] = w_cur_slice[i] ^ w_cur_par[(X + 4) % 5] ^
                        w_prev_par[(X + 1) % 5];
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.in_ready  = (r_state == S_LOAD);
   assign bus.out_valid = (r_state == S_EMIT);
   assign bus.out_line  = (r_state == S_EMIT) ? w_mix : '0;

   // busy also covers the cycle of the first accept of a frame (wr index
   // still 0), including an accept that lands in the done cycle.
   assign busy         = (r_state == S_EMIT) | (r_wr_idx != '0) | w_in_fire;
   assign done         = r_done;
   assign o_dbg_state  = r_state;
   assign o_dbg_rd_idx = r_rd_idx;

endmodule

// File: tb/tb_theta_column_parity.sv
module tb_theta_column_parity;
  localparam int N     = 25;
  localparam int LINES = 64;
  localparam int AW    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  theta_column_parity_if #(.N(N)) bus ();
  logic          busy;
  logic          done;
  logic          dbg_state;
  logic [AW-1:0] dbg_rd_idx;

  theta_column_parity #(.N(N), .LINES(LINES), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .o_dbg_state  (dbg_state),
    .o_dbg_rd_idx (dbg_rd_idx)
  );

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] fr[LINES];
  logic [N-1:0] stim[LINES];
  logic [N-1:0] cap[LINES];
  int           in_cnt  = 0;
  int           out_idx = 0;
  int           n_done  = 0;
  bit           pend_done = 1'b0;
  bit           armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit colpar(input logic [N-1:0] s, input int x);
    bit p;
    p = 1'b0;
    for (int y = 0; y < 5; y++) p = p ^ s[5*y + x];
    return p;
  endfunction

  function automatic logic [N-1:0] model_out(input int z);
    logic [N-1:0] o;
    int prev;
    prev = (z + LINES - 1) % LINES;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        o[5*y + x] = fr[z][5*y + x] ^ colpar(fr[z], (x + 4) % 5) ^ colpar(fr[prev], (x + 1) % 5);
    return o;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (armed) begin : cmp
      bit ev;
      ev = (exp_q.size() != 0);
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      chk("in_ready", 32'(bus.in_ready), 32'(!ev));
      chk("done", 32'(done), 32'(pend_done));
      chk("busy", 32'(busy), 32'(ev || in_cnt != 0 || (bus.in_valid && !ev)));
      if (ev) chk("out_line", 32'(bus.out_line), 32'(exp_q[0]));
      else    chk("out_line_idle", 32'(bus.out_line), 32'h0);
      if (done) n_done++;
      if (rst) begin
        in_cnt = 0;
        out_idx = 0;
        exp_q.delete();
        pend_done = 1'b0;
      end else begin
        pend_done = 1'b0;
        if (ev && bus.out_ready) begin
          cap[out_idx] = bus.out_line;
          out_idx++;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) pend_done = 1'b1;
        end else if (!ev && bus.in_valid) begin
          fr[in_cnt] = bus.in_line;
          in_cnt++;
          if (in_cnt == LINES) begin
            for (int z = 0; z < LINES; z++) exp_q.push_back(model_out(z));
            in_cnt = 0;
            out_idx = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < LINES; k++) stim[k] = '0;
  endtask

  task automatic rand_stim();
    for (int k = 0; k < LINES; k++) stim[k] = N'($urandom);
  endtask

  task automatic send_frame(input int gap_pct, input int stall_at, input bit hold_valid,
                            input bit rnd_ready, input int rst_at);
    int n;
    int cyc;
    bit hs;
    bit stalled;
    logic [N-1:0] held;
    for (int k = 0; k < LINES; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_line  = stim[k];
      tick();
    end
    bus.in_valid = hold_valid;
    bus.in_line  = N'($urandom);
    n = 0;
    cyc = 0;
    stalled = 1'b0;
    while (n < LINES && cyc < 4000) begin
      if (n == rst_at) begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rd_idx", 32'(dbg_rd_idx), 32'h0);
        return;
      end
      if (n == stall_at && !stalled) begin
        stalled = 1'b1;
        held = bus.out_line;
        for (int s = 0; s < 5; s++) begin
          bus.out_ready = 1'b0;
          tick();
          chk("stall_rd_idx", 32'(dbg_rd_idx), 32'(stall_at));
          chk("stall_out_line", 32'(bus.out_line), 32'(held));
          chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
        end
      end
      bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      hs = bus.out_valid && bus.out_ready;
      tick();
      cyc++;
      if (hs) n++;
    end
    if (n < LINES) chk("emit_timeout", 32'(n), 32'(LINES));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_line   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
    chk("reset_out_line", 32'(bus.out_line), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_rd_idx", 32'(dbg_rd_idx), 32'h0);
    rst = 1'b0;

    // hand-computed pins on the reference model
    for (int k = 0; k < LINES; k++) fr[k] = '0;
    fr[0] = 25'h0000001;
    chk("model_s0_out0", 32'(model_out(0)), 32'h0210843);
    chk("model_s0_out1", 32'(model_out(1)), 32'h1084210);
    chk("model_s0_out2", 32'(model_out(2)), 32'h0);
    fr[0] = '0;
    fr[63] = 25'h0000004;
    chk("model_s63_out63", 32'(model_out(63)), 32'h084210C);
    chk("model_s63_out0", 32'(model_out(0)), 32'h0210842);
    fr[63] = '0;
    fr[5] = 25'h0000021;
    chk("model_s5_out5", 32'(model_out(5)), 32'h0000021);
    armed = 1'b1;

    // all-zero frame
    clear_stim();
    send_frame(0, -1, 1'b0, 1'b0, -1);
    tick();
    chk("zero_done_count", 32'(n_done), 32'd1);
    chk("zero_cap0", 32'(cap[0]), 32'h0);
    chk("zero_cap63", 32'(cap[63]), 32'h0);

    // single bit in slice 0
    clear_stim();
    stim[0] = 25'h0000001;
    send_frame(0, -1, 1'b0, 1'b0, -1);
    tick();
    chk("s0_cap0", 32'(cap[0]), 32'h0210843);
    chk("s0_cap1", 32'(cap[1]), 32'h1084210);
    chk("s0_cap2", 32'(cap[2]), 32'h0);

    // wrap: slice 63 feeds slice 0
    clear_stim();
    stim[63] = 25'h0000004;
    send_frame(0, -1, 1'b0, 1'b0, -1);
    tick();
    chk("wrap_cap63", 32'(cap[63]), 32'h084210C);
    chk("wrap_cap0", 32'(cap[0]), 32'h0210842);
    chk("wrap_cap62", 32'(cap[62]), 32'h0);

    // even column parity cancels
    clear_stim();
    stim[5] = 25'h0000021;
    send_frame(0, -1, 1'b0, 1'b0, -1);
    tick();
    chk("even_cap5", 32'(cap[5]), 32'h0000021);
    chk("even_cap6", 32'(cap[6]), 32'h0);

    // backpressure at rd_idx 10 with in_valid held high during emit
    rand_stim();
    send_frame(30, 10, 1'b1, 1'b0, -1);
    tick();

    // reset mid-emit at rd_idx 30
    rand_stim();
    d0 = n_done;
    send_frame(0, -1, 1'b0, 1'b0, 30);
    tick();
    tick();
    chk("rst_no_done", 32'(n_done), 32'(d0));

    // full frames after reset, with gaps and random out_ready
    rand_stim();
    send_frame(40, -1, 1'b0, 1'b1, -1);
    rand_stim();
    send_frame(20, -1, 1'b1, 1'b1, -1);
    repeat (3) tick();
    chk("final_done_count", 32'(n_done), 32'd7);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // safety net against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
